// File: rtl/xor_parity_pkg.sv
// Shared definitions for the streaming XOR parity accumulator.
//   ST_IDLE / ST_ACC / ST_HOLD : FSM state encodings
//   state_e                    : enumerated FSM state type built on those encodings
//   sat_inc                    : saturating increment for counters up to 32 bits wide
package xor_parity_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_ACC  = ST_ACC,
      S_HOLD = ST_HOLD
   } state_e;

   // Increment v, clamped at the all-ones value of a w-bit counter.
   // Callers zero-extend into 32 bits and truncate the result back.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : (v + 32'd1);
   endfunction

endpackage

// File: rtl/xor_reduce.sv
// Combinational XOR reduction: y = ^x.
//   x : WIDTH-bit input word
//   y : parity of x (1 when an odd number of bits are set)
module xor_reduce #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] x,
   output logic             y
);

   assign y = ^x;

endmodule

// File: rtl/xor_parity_accumulator.sv
// Streaming XOR parity engine over multi-beat frames of WIDTH-bit words.
// Accumulates column (lane-wise) parity and beat count per frame and
// presents a registered result with frame parity and expected-parity mismatch.
//
// Optional feature: define XOR_PARITY_ERR_CNT_EN to build a saturating
// mismatch counter on err_count; otherwise err_count is tied to 0.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active-high
//   odd_mode   : 0 even / 1 odd parity, taken on the accepted last beat
//   in_valid   : input beat valid
//   in_ready   : input beat ready (!out_valid || out_ready)
//   in_data    : input word
//   in_last    : final beat of frame
//   in_exp_par : expected frame parity, taken on the accepted last beat
//   out_valid  : result valid
//   out_ready  : result accepted by consumer
//   out_parity : frame parity ^ odd_mode
//   out_lanes  : bitwise XOR of all words in the frame
//   out_beats  : beats in frame, saturating
//   out_err    : out_parity != expected parity
//   err_count  : saturating count of accepted results with out_err=1
//
// state  | meaning
// IDLE   | no frame open, no result pending
// ACC    | frame open, no result pending
// HOLD   | result pending (out_valid=1); a frame may be open in the background
module xor_parity_accumulator
   import xor_parity_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             odd_mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_exp_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic [WIDTH-1:0] out_lanes,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_err,
   output logic [CNT_W-1:0] err_count
);

   state_e           state_q;
   logic             frame_open_q;
   logic [WIDTH-1:0] lanes_q;
   logic [CNT_W-1:0] beats_q;

   logic             out_valid_q;
   logic             out_parity_q;
   logic [WIDTH-1:0] out_lanes_q;
   logic [CNT_W-1:0] out_beats_q;
   logic             out_err_q;

   logic             beat_acc;
   logic             res_acc;
   logic             frame_open_d;
   logic [WIDTH-1:0] lanes_d;
   logic [CNT_W-1:0] beats_d;
   logic             lane_par;
   logic             parity_d;

   assign in_ready = !out_valid_q || out_ready;
   assign beat_acc = in_valid && in_ready;
   assign res_acc  = out_valid_q && out_ready;

   // The first beat of a frame reloads the accumulators instead of folding
   // into whatever the previous frame left behind.
   always_comb begin
      lanes_d      = in_data;
      beats_d      = CNT_W'(1);
      frame_open_d = frame_open_q;
      if (frame_open_q) begin
         lanes_d = lanes_q ^ in_data;
         beats_d = CNT_W'(sat_inc(32'(beats_q), CNT_W));
      end
      if (beat_acc) begin
         frame_open_d = !in_last;
      end
   end

   xor_reduce #(.WIDTH(WIDTH)) u_reduce (
      .x (lanes_d),
      .y (lane_par)
   );

   assign parity_d = lane_par ^ odd_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         frame_open_q <= 1'b0;
         lanes_q      <= '0;
         beats_q      <= '0;
         out_valid_q  <= 1'b0;
         out_parity_q <= 1'b0;
         out_lanes_q  <= '0;
         out_beats_q  <= '0;
         out_err_q    <= 1'b0;
      end else begin
         frame_open_q <= frame_open_d;

         if (beat_acc && !in_last) begin
            lanes_q <= lanes_d;
            beats_q <= beats_d;
         end

         // A last beat can only be accepted in HOLD when the pending result
         // is taken in the same cycle, so loading the new result here is safe.
         if (beat_acc && in_last) begin
            out_valid_q  <= 1'b1;
            out_parity_q <= parity_d;
            out_lanes_q  <= lanes_d;
            out_beats_q  <= beats_d;
            out_err_q    <= parity_d ^ in_exp_par;
         end else if (res_acc) begin
            out_valid_q  <= 1'b0;
         end

         case (state_q)
            S_IDLE, S_ACC: begin
               if (beat_acc) begin
                  state_q <= in_last ? S_HOLD : S_ACC;
               end
            end
            S_HOLD: begin
               if (res_acc && !(beat_acc && in_last)) begin
                  state_q <= frame_open_d ? S_ACC : S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_parity = out_parity_q;
   assign out_lanes  = out_lanes_q;
   assign out_beats  = out_beats_q;
   assign out_err    = out_err_q;

`ifdef XOR_PARITY_ERR_CNT_EN
   logic [CNT_W-1:0] err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (res_acc && out_err_q) begin
         err_cnt_q <= CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = '0;
`endif

endmodule
